alu_serial: RTL

Parametrised bit-serial N-bit ALU built around the existing `alu_1bit` slice. It accepts two WIDTH-bit operands and an op code on a start strobe, then processes one bit per clock, LSB first, through a single slice and a carry flop. It returns the result with carry, overflow and zero flags and a one-cycle done pulse. It is the multi-bit, clocked successor to the 1-bit slice and is the datapath core for later multi-cycle units.

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_serial_if.sv | 26 ++
 rtl/alu_1bit.sv | 31 +++
 rtl/alu_serial.sv | 133 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op codes and FSM state encoding for the bit-serial ALU.
package alu_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_serial_if.sv
// Request/result bundle of the bit-serial ALU; master drives requests, slave returns results.
interface alu_serial_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] z;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, op, a, b, cin,
        input  busy, done, z, cout, ovf, zero
    );

    modport slave (
        input  start, op, a, b, cin,
        output busy, done, z, cout, ovf, zero
    );
endinterface

// File: rtl/alu_1bit.sv
// One-bit ALU slice: AND, OR or full-add of a, b and cin; carry is 0 for logic ops.
module alu_1bit
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [1:0] s_op,
    output logic       z,
    output logic       cout
);

    // Slice function select
    always_comb begin
        z    = 1'b0;
        cout = 1'b0;
        case (s_op)
            OP_AND: z = a & b;
            OP_OR:  z = a | b;
            OP_ADD: begin
                z    = a ^ b ^ cin;
                cout = (a & b) | (a & cin) | (b & cin);
            end
            default: begin
                z    = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial WIDTH-bit ALU: one bit per clock, LSB first, through a single alu_1bit slice.
module alu_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_serial_if.slave  bus
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] part_q;
    logic [WIDTH-1:0] z_q;
    logic [1:0]       op_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;
    logic             busy_q;
    logic             done_q;

    logic             slice_b;
    logic [1:0]       slice_op;
    logic             slice_z;
    logic             slice_cout;
    logic             is_arith;
    logic             carry_init_d;
    logic [WIDTH-1:0] part_d;

    // SUB runs as ADD of the inverted b-bit with the carry flop seeded to 1
    always_comb begin
        slice_b  = b_sh_q[0];
        slice_op = op_q;
        is_arith = 1'b0;
        if (op_q == OP_SUB) begin
            slice_b  = ~b_sh_q[0];
            slice_op = OP_ADD;
            is_arith = 1'b1;
        end else if (op_q == OP_ADD) begin
            is_arith = 1'b1;
        end else begin
            is_arith = 1'b0;
        end
    end

    // Carry seed chosen from the incoming op at the accepted start
    always_comb begin
        carry_init_d = 1'b0;
        case (bus.op)
            OP_ADD:  carry_init_d = bus.cin;
            OP_SUB:  carry_init_d = 1'b1;
            default: carry_init_d = 1'b0;
        endcase
    end

    assign part_d = {slice_z, part_q[WIDTH-1:1]};

    alu_1bit u_slice (
        .a    (a_sh_q[0]),
        .b    (slice_b),
        .cin  (carry_q),
        .s_op (slice_op),
        .z    (slice_z),
        .cout (slice_cout)
    );

    // Control FSM, operand shifters and registered result/flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            a_sh_q  <= {WIDTH{1'b0}};
            b_sh_q  <= {WIDTH{1'b0}};
            part_q  <= {WIDTH{1'b0}};
            z_q     <= {WIDTH{1'b0}};
            op_q    <= OP_AND;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_sh_q  <= bus.a;
                        b_sh_q  <= bus.b;
                        op_q    <= bus.op;
                        carry_q <= carry_init_d;
                        cnt_q   <= {CW{1'b0}};
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh_q  <= {1'b0, a_sh_q[WIDTH-1:1]};
                    b_sh_q  <= {1'b0, b_sh_q[WIDTH-1:1]};
                    part_q  <= part_d;
                    carry_q <= slice_cout;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        // carry_q here is the carry into the MSB
                        z_q     <= part_d;
                        cout_q  <= is_arith & slice_cout;
                        ovf_q   <= is_arith & (carry_q ^ slice_cout);
                        zero_q  <= (part_d == {WIDTH{1'b0}});
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.z    = z_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;

endmodule
